// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the imem request/response handshake and
// presents one instruction per slot to decode, with a one-entry skid buffer
// and wrong-path squashing on jump/branch redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        AnyStall,
    input  logic        Jump_ID,
    input  logic [25:0] JumpTgt_ID,
    input  logic        BrTaken_EX,
    input  logic [31:0] BrTgt_EX,
    output logic        IMemReq_IF,
    output logic [31:0] IMemAddr_IF,
    input  logic        IMemAck,
    input  logic        IMemRdValid,
    input  logic [31:0] IMemRdData,
    output logic        FetchValid_IF,
    output logic [31:0] FetchData_IF,
    output logic [31:0] FetchPc_IF
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]   skid_data_q, skid_data_d;
    logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
    logic              req_q;
    logic [XLEN-1:0]   addr_q;

    logic              consume;
    logic              jump_fire;
    logic              redirect;
    logic              rsp;
    logic              ack;
    logic              jump_carry;
    logic [3:0]        jump_hi;
    logic [XLEN-1:0]   redirect_tgt;

    // Handshake qualifiers and redirect target selection
    always_comb begin
        consume      = out_valid_q && !AnyStall;
        jump_fire    = Jump_ID && consume;
        redirect     = BrTaken_EX || jump_fire;
        rsp          = (state_q == S_WAIT) && IMemRdValid;
        ack          = (state_q == S_REQ) && IMemAck;
        // pc+4 carries into bit 28 only when bits [27:2] are all ones
        jump_carry   = &out_pc_q[27:2];
        jump_hi      = out_pc_q[31:28] + 4'(jump_carry);
        redirect_tgt = BrTaken_EX ? BrTgt_EX : {jump_hi, JumpTgt_ID, 2'b00};
    end

    // Next-state: output slot / skid placement, fetch pc and request FSM
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        if (redirect) begin
            pc_d         = redirect_tgt & ~XLEN'(3);
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || consume) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
                if (rsp) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = IMemRdData;
                    skid_pc_d    = req_pc_q;
                end
            end else if (rsp) begin
                out_valid_d = 1'b1;
                out_data_d  = IMemRdData;
                out_pc_d    = req_pc_q;
            end
        end else if (rsp) begin
            skid_valid_d = 1'b1;
            skid_data_d  = IMemRdData;
            skid_pc_d    = req_pc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!redirect && !skid_valid_d) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (ack) begin
                    if (redirect) begin
                        state_d = S_DROP;
                    end else begin
                        state_d  = S_WAIT;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + XLEN'(4);
                    end
                end else if (redirect) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_d = IMemRdValid ? S_IDLE : S_DROP;
                end else if (IMemRdValid) begin
                    state_d = skid_valid_d ? S_IDLE : S_REQ;
                end
            end
            S_DROP: begin
                if (IMemRdValid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered-output update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_pc_q    <= '0;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_pc_q    <= skid_pc_d;
            req_q        <= (state_d == S_REQ);
            addr_q       <= pc_d;
        end
    end

    assign IMemReq_IF    = req_q;
    assign IMemAddr_IF   = addr_q;
    assign FetchValid_IF = out_valid_q;
    assign FetchData_IF  = out_data_q;
    assign FetchPc_IF    = out_pc_q;

endmodule
